// File: rtl/perf_event_monitor.sv
// perf_event_monitor: cycle counter plus NUM_EVT event counters with freeze, clear,
// auto-stop and a registered read port. Define PERF_MON_SAT_EN to saturate instead of wrap.
module perf_event_monitor #(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = 32,
  parameter int STOP_CYCLE = 30,
  parameter int SEL_W      = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               clr_i,
  input  logic               freeze_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  input  logic               rd_en_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_valid_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               done_o,
  output logic               run_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] ALL_ONES  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLE - 1);

  state_e           state_q;
  logic             run_q;
  logic             done_q;
  logic             count_en;
  logic             stop_hit;
  logic [NUM_EVT:0] inc;
  logic [CNT_W-1:0] cnt_all [NUM_EVT+1];
  logic [CNT_W-1:0] rd_mux;
  logic [CNT_W-1:0] rd_data_q;
  logic             rd_valid_q;

  // Index 0 is the cycle counter; index k+1 is event channel k.
  assign count_en = (state_q == S_RUN) && start_i && !freeze_i && !clr_i;
  assign inc      = {evt_i, 1'b1} & {(NUM_EVT + 1){count_en}};
  assign stop_hit = (STOP_CYCLE != 0) && (cnt_all[0] == STOP_LAST);

  for (genvar gi = 0; gi <= NUM_EVT; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_i) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (inc[gi]) begin
        if (cnt_q == ALL_ONES) begin
          ovf_d = 1'b1;
`ifdef PERF_MON_SAT_EN
          cnt_d = ALL_ONES;
`else
          cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt_all[gi] = cnt_q;
    assign ovf_o[gi]   = ovf_q;
  end

  // run/done are registered alongside the state so they never see input glitches.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (clr_i) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
          end
        end
        S_RUN: begin
          if (!start_i) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
          end else if (freeze_i) begin
            state_q <= S_FROZEN;
            run_q   <= 1'b0;
          end else if (stop_hit) begin
            state_q <= S_DONE;
            run_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_FROZEN: begin
          if (!start_i) begin
            state_q <= S_IDLE;
          end else if (!freeze_i) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          run_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    if (32'(rd_sel_i) <= 32'(NUM_EVT)) begin
      rd_mux = cnt_all[rd_sel_i];
    end
  end

  // Reads sample pre-update counter values, so a read alongside clr_i sees the old count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign cycle_o    = cnt_all[0];
  assign run_o      = run_q;
  assign done_o     = done_q;

endmodule

// File: doc/perf_event_monitor.md
Name: perf_event_monitor

Overview:
- Synthesizable, parametrised performance monitor for the pipelined CPU. Replaces bench-side cycle, stall and flush tallies with in-design counters.
- Counts core cycles plus NUM_EVT independent event lines, for example stall, flush, branch-taken and load-use.
- Supports freeze, clear, auto-stop after a programmed cycle count, and a registered read port. Sits beside the CPU top and is driven by the hazard unit and control strobes.

Parameters:
- NUM_EVT, 4: number of event counter channels (1..16).
- CNT_W, 32: width of every counter (8..64).
- STOP_CYCLE, 30: cycle count at which counting auto-stops; 0 means never stop.
- SEL_W, $clog2(NUM_EVT+1): read-select width (derived, do not override).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  run enable, level sensitive, same signal as the CPU start
- evt_i  in  NUM_EVT  event strobes; bit k high means count 1 on channel k this cycle
- clr_i  in  1  synchronous clear of all counters, flags and state
- freeze_i  in  1  pause counting while high
- rd_sel_i  in  SEL_W  0 selects the cycle counter; k in 1..NUM_EVT selects event counter k-1
- rd_en_i  in  1  read request
- rd_data_o  out  CNT_W  read data, registered
- rd_valid_o  out  1  high one cycle after rd_en_i
- cycle_o  out  CNT_W  live cycle counter
- ovf_o  out  NUM_EVT+1  sticky overflow flags; bit 0 is the cycle counter, bit k+1 is event k
- done_o  out  1  high while in DONE
- run_o  out  1  high while in RUN

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All counters 0, ovf_o 0.
  - State IDLE; rd_data_o 0, rd_valid_o 0, done_o 0, run_o 0.
- States: IDLE, RUN, FROZEN, DONE. Transitions are evaluated at posedge.
- IDLE: counters hold. start_i=1 goes to RUN. No counting happens in the cycle in which IDLE is sampled.
- RUN: every posedge adds 1 to the cycle counter and adds evt_i[k] to event counter k.
  - freeze_i=1 goes to FROZEN; that cycle is not counted.
  - start_i=0 goes to IDLE; not counted; counts are retained.
  - Priority: start_i low beats freeze_i.
- FROZEN: hold. freeze_i=0 returns to RUN. start_i=0 goes to IDLE.
- Auto-stop: when STOP_CYCLE≠0 and the cycle counter is STOP_CYCLE-1 in RUN:
  - This final cycle and its events are counted, so the cycle counter reaches STOP_CYCLE.
  - Next state is DONE.
- DONE: all counters hold regardless of start_i, freeze_i and evt_i. Only clr_i or reset exits.
- clr_i=1 has the highest synchronous priority:
  - Next cycle all counters and ovf_o are 0 and state is IDLE.
  - Events coincident with clr_i are discarded.
- Overflow: a counter at all-ones that increments wraps to 0 and sets its ovf_o bit. The bit stays set until clr_i or reset.
- Read port:
  - rd_en_i sampled at posedge N gives rd_data_o and rd_valid_o=1 at N+1.
  - Data is the counter value before the update at edge N.
  - rd_sel_i > NUM_EVT returns 0 with rd_valid_o=1.
  - rd_data_o holds its last value when rd_valid_o=0.
- Read during clr_i returns the pre-clear value.
- Reads are legal in every state.
- cycle_o, run_o and done_o are direct register outputs with no combinational path from inputs.

Optional Feature:
- Macro PERF_MON_SAT_EN.
- When defined: counters saturate at all-ones instead of wrapping, and ovf_o still sets on the first attempted increment past all-ones.
- When undefined: wrap-around as described in Behaviour.

Test Plan:
- Reset, then start_i=1 with evt_i=0 and STOP_CYCLE=30, run 40 cycles:
  - cycle_o=30, done_o=1 from the cycle after the 30th count.
  - Event counters 0; cycle_o stays 30 afterwards.
- RUN with evt_i[0] high for 3 cycles and evt_i[1] high for 2 cycles overlapping:
  - Read sel 1 gives 3, sel 2 gives 2, each one cycle after rd_en_i.
  - Read sel 5 with NUM_EVT=4 gives 0.
- freeze_i high for 5 cycles mid-run with evt_i=4'b1111:
  - No counter changes during freeze.
  - cycle_o resumes from its frozen value once freeze_i=0.
- CNT_W=8, STOP_CYCLE=0, evt_i[0] high for 257 cycles:
  - Event 0 count is 1 and ovf_o[1]=1.
  - With PERF_MON_SAT_EN defined: count is 255 and ovf_o[1]=1.
- clr_i pulsed in DONE and also in RUN with evt_i active:
  - All counters and ovf_o are 0 next cycle, state IDLE.
  - A read issued with clr_i returns the old value.
- Assert rst_i=0 mid-run, asynchronously between edges:
  - Outputs go to reset values immediately.
  - After release with start_i=1, counting restarts from 0.
